// File: rtl/npc_pkg.sv
// Shared encodings for the next-PC unit: branch kinds, control states and the
// default reset PC.
package npc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } brop_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } npc_state_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_brcmp.sv
// Signed branch-condition evaluator; purely combinational.
module npc_brcmp
  import npc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        brop,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              cond
);

  logic rs_neg_s;
  logic rs_zero_s;

  assign rs_neg_s  = rs_val[DATA_W-1];
  assign rs_zero_s = (rs_val == {DATA_W{1'b0}});

  // Condition select; the reserved encoding behaves like "no branch".
  always_comb begin
    cond = 1'b0;
    case (brop_e'(brop))
      BR_BEQ:  cond = (rs_val == rt_val);
      BR_BNE:  cond = (rs_val != rt_val);
      BR_BLEZ: cond = rs_neg_s | rs_zero_s;
      BR_BGTZ: cond = ~rs_neg_s & ~rs_zero_s;
      BR_BLTZ: cond = rs_neg_s;
      BR_BGEZ: cond = ~rs_neg_s;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC unit: sequential/branch/jump target selection with a stall hold slot.
// Optional taken-redirect counter is built when NPC_PERF_EN is defined.
module npc_unit
  import npc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = NPC_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [2:0]        brop,
  input  logic              j,
  input  logic              jal,
  input  logic              jr,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic [ADDR_W-1:0] link,
  output logic              taken,
  output logic              pending
`ifdef NPC_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  npc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_q, hold_d;

  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] br_tgt_s;
  logic [ADDR_W-1:0] jmp_tgt_s;
  logic [ADDR_W-1:0] jr_tgt_s;
  logic [ADDR_W-1:0] tgt_s;
  logic [27:0]       jidx_s;
  logic              br_cond_s;
  logic              commit_s;

  npc_brcmp #(.DATA_W(DATA_W)) u_brcmp (
    .brop   (brop),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .cond   (br_cond_s)
  );

  assign seq_s    = pc_q + ADDR_W'(4);
  assign br_off_s = ADDR_W'($signed({imm16, 2'b00}));
  assign br_tgt_s = seq_s + br_off_s;
  assign jidx_s   = {imm26, 2'b00};

  // Narrow PCs keep only the low bits of the jump index.
  if (ADDR_W > 28) begin : g_jmp_wide
    assign jmp_tgt_s = {pc_q[ADDR_W-1:28], jidx_s};
  end else begin : g_jmp_narrow
    assign jmp_tgt_s = jidx_s[ADDR_W-1:0];
  end

  if (DATA_W >= ADDR_W) begin : g_jr_trunc
    assign jr_tgt_s = rs_val[ADDR_W-1:0];
  end else begin : g_jr_ext
    assign jr_tgt_s = {{(ADDR_W-DATA_W){1'b0}}, rs_val};
  end

  assign taken = j | jal | jr | br_cond_s;

  // Redirect target and next-PC select; a latched redirect overrides new ones.
  always_comb begin
    tgt_s = br_tgt_s;
    if (jr) begin
      tgt_s = jr_tgt_s;
    end else if (j | jal) begin
      tgt_s = jmp_tgt_s;
    end else begin
      tgt_s = br_tgt_s;
    end
    if (state_q == ST_HOLD) begin
      npc = hold_q;
    end else if (taken) begin
      npc = tgt_s;
    end else begin
      npc = seq_s;
    end
  end

  // RUN/HOLD next-state, PC and hold-slot update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    commit_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          pc_d     = npc;
          commit_s = taken;
        end else if (taken) begin
          hold_d  = tgt_s;
          state_d = ST_HOLD;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_d     = hold_q;
          state_d  = ST_RUN;
          commit_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control state, PC and hold-slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RST;
      hold_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign pc      = pc_q;
  assign link    = seq_s;
  assign pending = (state_q == ST_HOLD);

`ifdef NPC_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of redirects that actually reached the PC.
  always_comb begin
    cnt_d = cnt_q;
    if (commit_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Redirect counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign perf_cnt = cnt_q;
`else
  logic unused_commit_s;
  assign unused_commit_s = commit_s;

  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: stimulus pushes expectations, a negedge
// monitor pops and compares them. Counter checks build with NPC_PERF_EN.
module tb_npc_unit;

  localparam int SG_PC = 0, SG_NPC = 1, SG_LINK = 2, SG_TAKEN = 3, SG_PEND = 4, SG_PERF = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [2:0]  brop;
  logic        j, jal, jr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val, rt_val;
  logic [31:0] pc, npc, link;
  logic        taken, pending;
  logic [1:0]  perf_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  npc_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (stall),
    .brop    (brop),
    .j       (j),
    .jal     (jal),
    .jr      (jr),
    .imm16   (imm16),
    .imm26   (imm26),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .pc      (pc),
    .npc     (npc),
    .link    (link),
    .taken   (taken),
    .pending (pending)
`ifdef NPC_PERF_EN
    ,
    .perf_cnt(perf_cnt)
`endif
  );

`ifndef NPC_PERF_EN
  assign perf_cnt = 2'd0;
`endif

  always #5 clk = ~clk;

  // Monitor: every queued expectation is compared against the settled outputs.
  always @(negedge clk) begin
    logic [31:0] act;
    exp_t        e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        SG_PC:    act = pc;
        SG_NPC:   act = npc;
        SG_LINK:  act = link;
        SG_TAKEN: act = {31'd0, taken};
        SG_PEND:  act = {31'd0, pending};
        default:  act = {30'd0, perf_cnt};
      endcase
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
    end
  end

  task automatic chk(input string nm, input int sg, input logic [31:0] v);
    sb.push_back('{name: nm, sig: sg, exp: v});
  endtask

  task automatic chk_perf(input string nm, input logic [31:0] v);
`ifdef NPC_PERF_EN
    chk(nm, SG_PERF, v);
`endif
  endtask

  task automatic idle();
    stall = 1'b0; brop = 3'd0; j = 1'b0; jal = 1'b0; jr = 1'b0;
    imm16 = 16'h0000; imm26 = 26'h0; rs_val = 32'h0; rt_val = 32'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle();
    #1;
    chk("rst_pc", SG_PC, 32'h3000); chk("rst_pend", SG_PEND, 32'd0);
    chk("rst_taken", SG_TAKEN, 32'd0); chk("rst_npc", SG_NPC, 32'h3004);
    chk_perf("rst_perf", 32'd0);
    next();
    reset_n = 1'b1;
    chk("seq0", SG_PC, 32'h3000);
    next(); chk("seq1", SG_PC, 32'h3004);
    next(); chk("seq2", SG_PC, 32'h3008);
    next(); chk("seq3", SG_PC, 32'h300C);
    next();

    // beq to self, then bne with equal operands, then a forward beq to 0x3010
    do_reset();
    brop = 3'd1; rs_val = 32'd5; rt_val = 32'd5; imm16 = 16'hFFFF;
    chk("beq_taken", SG_TAKEN, 32'd1); chk("beq_npc", SG_NPC, 32'h3000);
    next();
    brop = 3'd2;
    chk("beq_pc", SG_PC, 32'h3000); chk("bne_taken", SG_TAKEN, 32'd0); chk("bne_npc", SG_NPC, 32'h3004);
    next();
    brop = 3'd1; imm16 = 16'h0002;
    chk("bne_pc", SG_PC, 32'h3004); chk("beq_fwd_npc", SG_NPC, 32'h3010);
    next();
    idle(); j = 1'b1; imm26 = 26'h0220001;
    chk("j_pc", SG_PC, 32'h3010); chk("j_taken", SG_TAKEN, 32'd1);
    chk("j_npc", SG_NPC, 32'h0088_0004); chk("j_link", SG_LINK, 32'h3014);
    next();
    idle();
    chk("j_commit_pc", SG_PC, 32'h0088_0004); chk("j_commit_link", SG_LINK, 32'h0088_0008);
    next();

    // jal from 0x3010
    do_reset();
    brop = 3'd1; rs_val = 32'd1; rt_val = 32'd1; imm16 = 16'h0003;
    chk("beq3_npc", SG_NPC, 32'h3010);
    next();
    idle(); jal = 1'b1; imm26 = 26'h0220001;
    chk("jal_pc", SG_PC, 32'h3010); chk("jal_link", SG_LINK, 32'h3014);
    chk("jal_npc", SG_NPC, 32'h0088_0004); chk("jal_taken", SG_TAKEN, 32'd1);
    next();
    idle();
    chk("jal_commit_pc", SG_PC, 32'h0088_0004);
    next();

    // Stalled jr latches, a later jal is ignored, release loads 0x3100
    do_reset();
    brop = 3'd1; imm16 = 16'h0007;
    chk("beq7_npc", SG_NPC, 32'h3020);
    next();
    idle(); stall = 1'b1; jr = 1'b1; rs_val = 32'h3100;
    chk("jr_pc", SG_PC, 32'h3020); chk("jr_taken", SG_TAKEN, 32'd1);
    chk("jr_npc", SG_NPC, 32'h3100); chk("jr_pend0", SG_PEND, 32'd0);
    chk_perf("perf1", 32'd1);
    next();
    for (int k = 0; k < 2; k++) begin
      idle(); stall = 1'b1; jal = 1'b1; imm26 = 26'h0000100;
      chk("hold_pend", SG_PEND, 32'd1); chk("hold_pc", SG_PC, 32'h3020);
      chk("hold_npc", SG_NPC, 32'h3100); chk("hold_taken", SG_TAKEN, 32'd1);
      next();
    end
    idle();
    chk("rel_pend", SG_PEND, 32'd1); chk("rel_npc", SG_NPC, 32'h3100); chk("rel_pc", SG_PC, 32'h3020);
    next();
    jr = 1'b1; rs_val = 32'h3103;
    chk("after_pc", SG_PC, 32'h3100); chk("after_pend", SG_PEND, 32'd0);
    chk("jr_unal_npc", SG_NPC, 32'h3103); chk_perf("perf2", 32'd2);
    next();
    idle(); brop = 3'd1; imm16 = 16'hFFFF;
    chk("jr_unal_pc", SG_PC, 32'h3103); chk("jr_unal_link", SG_LINK, 32'h3107);
    chk("beq_self_npc", SG_NPC, 32'h3103); chk_perf("perf3", 32'd3);
    next();
    chk("self_pc", SG_PC, 32'h3103); chk_perf("perf_sat4", 32'd3);
    next();
    idle(); stall = 1'b1; jr = 1'b1; rs_val = 32'h3200;
    chk_perf("perf_sat5", 32'd3); chk("self2_pc", SG_PC, 32'h3103); chk("jr2_npc", SG_NPC, 32'h3200);
    next();

    // Condition table evaluated while held; npc stays on the latched target
    idle(); stall = 1'b1; brop = 3'd5; rs_val = 32'h8000_0000;
    chk("bltz_taken", SG_TAKEN, 32'd1); chk("held_npc", SG_NPC, 32'h3200); chk("held_pend", SG_PEND, 32'd1);
    next();
    brop = 3'd4; rs_val = 32'h0;
    chk("bgtz0_taken", SG_TAKEN, 32'd0);
    next();
    brop = 3'd7; rs_val = 32'h0; rt_val = 32'h0;
    chk("rsvd_taken", SG_TAKEN, 32'd0);
    next();
    brop = 3'd3; rs_val = 32'h0;
    chk("blez0_taken", SG_TAKEN, 32'd1);
    next();
    brop = 3'd6; rs_val = 32'h8000_0000;
    chk("bgez_neg_taken", SG_TAKEN, 32'd0); chk("held_pc", SG_PC, 32'h3103);
    next();

    // Reset asserted while held: immediate clear, then RESET_PC+4 after release
    reset_n = 1'b0;
    idle();
    chk("hrst_pend", SG_PEND, 32'd0); chk("hrst_pc", SG_PC, 32'h3000);
    chk("hrst_npc", SG_NPC, 32'h3004); chk_perf("hrst_perf", 32'd0);
    next();
    reset_n = 1'b1;
    chk("hrst_rel_pc", SG_PC, 32'h3000);
    next();
    chk("hrst_fetch_pc", SG_PC, 32'h3004); chk("hrst_fetch_pend", SG_PEND, 32'd0);
    next();

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC and target width in bits (>= 8).
REQ-002 Parameter DATA_W, default 32, meaning width of the compared register operands.
REQ-003 Parameter RESET_PC, default 32'h0000_3000, meaning PC value loaded at reset, truncated to ADDR_W.
REQ-004 Parameter CNT_W, default 16, meaning taken-redirect counter width (used only with NPC_PERF_EN).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC this cycle.
REQ-008 brop  in  3  branch kind: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
REQ-009 j, jal, jr  in  1 each  jump strobes, mutually exclusive with each other and with brop!=0.
REQ-010 imm16  in  16  branch offset, in words; imm26  in  26  jump index.
REQ-011 rs_val, rt_val  in  DATA_W each  branch operands; rs_val is also the jr target.
REQ-012 pc  out  ADDR_W  current PC register; npc  out  ADDR_W  value PC takes on next unstalled edge.
REQ-013 link  out  ADDR_W  pc+4, the jal return address; taken  out  1  redirect selected this cycle.
REQ-014 pending  out  1  a redirect is latched awaiting stall release.
REQ-015 perf_cnt  out  CNT_W  taken-redirect count (present only with NPC_PERF_EN).

Function
REQ-016 Sequential target pc+4; all adds are modulo 2^ADDR_W.
REQ-017 Branch target = pc+4 + (sign-extended imm16 << 2); jump target = {pc[ADDR_W-1:28], imm26, 2'b00} (for ADDR_W < 28, the low ADDR_W bits of {imm26,2'b00}); jr target = rs_val[ADDR_W-1:0].
REQ-018 Branch conditions are signed: beq rs==rt, bne rs!=rt, blez rs<=0, bgtz rs>0, bltz rs<0, bgez rs>=0.
REQ-019 taken = j | jal | jr | (branch condition true); combinational, independent of stall.
REQ-020 States: RUN and HOLD; reset enters RUN.
REQ-021 RUN, stall=0: pc <= npc (taken ? target : pc+4).
REQ-022 RUN, stall=1, taken=0: pc held, state RUN.
REQ-023 RUN, stall=1, taken=1: pc held, target latched into hold register, state -> HOLD, pending=1 from next cycle.
REQ-024 HOLD: npc = hold register; new redirects are ignored (first redirect wins); taken still reflects current inputs.
REQ-025 HOLD, stall=0: pc <= hold register, state -> RUN, pending=0 next cycle.
REQ-026 RUN with stall=0 and taken=1 in the same cycle: redirect applies directly, never enters HOLD.
REQ-027 Unaligned jr target is loaded unmodified; no alignment fault is raised.

Reset
REQ-028 reset_n low asynchronously forces pc=RESET_PC, state RUN, hold register 0, pending 0, perf_cnt 0.
REQ-029 Reset asserted in HOLD discards the latched redirect; first edge after release fetches RESET_PC+4 when stall=0.

Configuration
REQ-030 Macro NPC_PERF_EN defined: perf_cnt exists and increments by 1 on each edge where a redirect is committed to pc (REQ-021 with taken=1, or REQ-025); saturates at all-ones.
REQ-031 NPC_PERF_EN undefined: perf_cnt port and counter logic are absent; all other behaviour identical.

Structure
REQ-032 Shared package npc_pkg holds brop encodings, state enum {RUN, HOLD}, and the default RESET_PC constant.
REQ-033 Sub-module npc_brcmp (combinational, DATA_W parameter) evaluates the branch condition from brop, rs_val, rt_val.

Verification
REQ-034 Reset release, stall=0, no redirect, 3 edges -> pc = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-035 pc=0x3000, brop=beq, rs=rt=5, imm16=0xFFFF -> taken=1, npc=0x3000; brop=bne same operands -> taken=0, npc=0x3004.
REQ-036 pc=0x3010, j=1, imm26=0x0220001 -> npc=0x00880004; jal=1 -> link=0x3014.
REQ-037 pc=0x3020, stall=1, jr=1, rs_val=0x3100 for 1 cycle, then jal to another target while stall stays 1 for 2 cycles, then stall=0 -> pending=1 during hold, pc=0x3020 while stalled, then pc=0x3100.
REQ-038 brop=bltz, rs_val=0x8000_0000 -> taken=1; brop=bgtz, rs_val=0 -> taken=0; brop=7 -> taken=0.
REQ-039 With NPC_PERF_EN and CNT_W=2: 5 committed redirects -> perf_cnt=3; reset_n pulse low in HOLD -> pending=0, pc=0x3000, perf_cnt=0 immediately.
